// File: rtl/control_pkg.sv
// Shared state type and instruction-field helpers for the control sequencer.
package control_pkg;

  typedef enum logic {IDLE, RUN} seq_state_e;

  function automatic int nn_start_pos(input int act_w);
    return act_w;
  endfunction

  function automatic int load_inputs_pos(input int act_w);
    return act_w + 1;
  endfunction

  function automatic int load_weights_pos(input int act_w);
    return act_w + 2;
  endfunction

  function automatic int load_bias_pos(input int act_w);
    return act_w + 3;
  endfunction

  function automatic int repeat_pos(input int act_w);
    return act_w + 4;
  endfunction

  function automatic int instr_width(input int act_w, input int cnt_w);
    return act_w + 4 + cnt_w;
  endfunction

  // Builds an instruction word from its fields; unused upper bits stay zero.
  function automatic logic [31:0] pack_instr(input int act_w, input int cnt_w, input int act,
                                             input logic nn, input logic li, input logic lw,
                                             input logic lb, input int rep);
    logic [31:0] w;
    w = 32'(act) & ((32'd1 << act_w) - 32'd1);
    w[nn_start_pos(act_w)] = nn;
    w[load_inputs_pos(act_w)] = li;
    w[load_weights_pos(act_w)] = lw;
    w[load_bias_pos(act_w)] = lb;
    w = w | ((32'(rep) & ((32'd1 << cnt_w) - 32'd1)) << repeat_pos(act_w));
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO; occupancy is tracked by a count register so full/empty
// never depend on pointer comparison.
module instr_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/control_sequencer.sv
// Queued control sequencer: pops instructions from a FIFO and drives registered
// control strobes for repeat+1 unstalled cycles each.
module control_sequencer
  import control_pkg::*;
#(
  parameter int ACT_W = 2,
  parameter int CNT_W = 4,
  parameter int DEPTH = 4,
  localparam int INSTR_W = ACT_W + 4 + CNT_W,
  localparam int FC_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               stall,
  input  logic               abort,
  output logic [ACT_W-1:0]   activation_datapath,
  output logic               nn_start,
  output logic               load_inputs,
  output logic               load_weights,
  output logic               load_bias,
  output logic               busy,
  output logic               seq_done,
  output logic [FC_W-1:0]    fifo_count
);

  localparam int CTRL_W  = ACT_W + 4;
  localparam int REP_LSB = repeat_pos(ACT_W);
  localparam int NN_POS  = nn_start_pos(ACT_W);
  localparam int LI_POS  = load_inputs_pos(ACT_W);
  localparam int LW_POS  = load_weights_pos(ACT_W);
  localparam int LB_POS  = load_bias_pos(ACT_W);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] cur_q, cur_d, out_q, out_d;
  logic              done_q, done_d;
  logic [INSTR_W-1:0] head;
  logic              full, empty, push, pop;

  assign instr_ready = ~full;
  assign push        = instr_valid & ~full & ~abort;

  instr_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (abort),
    .wr_data (instr),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // Outputs default to zero so a stall edge produces a bubble while the
  // held instruction (cur_q) and remaining count stay frozen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    out_d   = '0;
    done_d  = 1'b0;
    pop     = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!stall) begin
      if (state_q == RUN && cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
        out_d = cur_q;
      end else if (!empty) begin
        pop     = 1'b1;
        cur_d   = head[CTRL_W-1:0];
        cnt_d   = head[REP_LSB +: CNT_W];
        out_d   = head[CTRL_W-1:0];
        state_d = RUN;
      end else if (state_q == RUN) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign activation_datapath = out_q[ACT_W-1:0];
  assign nn_start            = out_q[NN_POS];
  assign load_inputs         = out_q[LI_POS];
  assign load_weights        = out_q[LW_POS];
  assign load_bias           = out_q[LB_POS];
  assign seq_done            = done_q;
  assign busy                = (state_q == RUN) | ~empty;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Parametrised, queued successor to the combinational instruction decoder. Accepts instruction words over a valid/ready handshake into a small FIFO and pops them in order. Drives registered per-cycle control strobes (activation routing, nn_start, load_inputs, load_weights, load_bias) for a programmable repeat count. Supports stall and abort, and sits between the host/instruction source and the systolic array, accumulator and bias datapath.

Parameters:
ACT_W, 2, width of activation_datapath select field
CNT_W, 4, width of per-instruction repeat field; instruction held for repeat+1 cycles
DEPTH, 4, instruction FIFO depth; power of two, >=2
(derived localparam) INSTR_W = ACT_W+4+CNT_W (default 10)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
instr  input  INSTR_W  instruction word; layout below
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  FIFO can accept; equals !full
stall  input  1  datapath back-pressure; freezes the sequencer
abort  input  1  synchronous flush of the FIFO and the current instruction
activation_datapath  output  ACT_W  activation routing select
nn_start  output  1  accumulator start strobe
load_inputs  output  1  input load strobe
load_weights  output  1  weight load strobe
load_bias  output  1  bias load strobe
busy  output  1  state==RUN or FIFO non-empty
seq_done  output  1  one-cycle pulse when the queue drains to idle
fifo_count  output  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Instruction layout: [ACT_W-1:0] act; [ACT_W] nn_start; [ACT_W+1] load_inputs; [ACT_W+2] load_weights; [ACT_W+3] load_bias; [ACT_W+4 +: CNT_W] repeat. At defaults the low 6 bits match the legacy 6-bit encoding.
- Reset (rst=0, async): FIFO empty, state IDLE, counter 0. All control outputs, seq_done and busy are 0; fifo_count is 0; instr_ready is 1 once rst deasserts.
- Push: instr_valid & instr_ready at edge E writes the FIFO. No push while full; instr_valid while full is ignored and the word is held by the source.
- All control outputs are registered.
- States: IDLE, RUN.
- IDLE:
  - FIFO non-empty and !stall at edge: pop the head, load the control register, set cnt=repeat, go to RUN.
  - Minimum latency: push at E0, pop at E1, strobes visible in the cycle after E1.
- RUN:
  - Each edge with !stall: if cnt!=0, cnt-=1 and outputs are unchanged.
  - If cnt==0 and FIFO non-empty: pop the next instruction back-to-back, with no bubble.
  - If cnt==0 and FIFO empty: clear outputs to 0, go to IDLE, and pulse seq_done for the following cycle.
- Stall:
  - While stall=1, all control outputs read 0 (a bubble) and cnt, state and FIFO read pointer freeze.
  - Pushes still occur.
  - Dropping stall resumes with the remaining cycles; total asserted cycles per instruction stay repeat+1.
- Abort at edge: FIFO emptied, state IDLE, outputs 0, seq_done not pulsed. A simultaneous push is discarded. Abort has priority over stall and push.
- Simultaneous push and pop on the same edge: both occur; fifo_count is unchanged.
- Reset mid-RUN: outputs drop to 0 asynchronously and the queue is lost.
- Pointer wrap: modulo DEPTH. Full/empty use a count register, not pointer compare.

Decomposition:
- control_pkg: state enum {IDLE,RUN}; field offset functions of ACT_W/CNT_W; pack_instr() helper for benches.
- Sub-module instr_fifo (params WIDTH, DEPTH): synchronous FIFO with push, pop, flush, full, empty and count outputs.
- Sequencer FSM and output register live in the top module.

Test Plan:
- Reset then idle: rst low mid-cycle -> all outputs 0 immediately; after release instr_ready=1, busy=0, fifo_count=0.
- Single instruction: push 0x091 (act=01, load_weights, repeat=2) -> activation_datapath=01 and load_weights=1 for exactly 3 cycles starting 2 edges after push; then 0; seq_done pulses once; busy falls.
- Back-to-back: push 0x004 (nn_start, repeat=0) then 0x008 (load_inputs, repeat=0) on consecutive cycles -> nn_start for 1 cycle, immediately followed by load_inputs for 1 cycle, no gap; one seq_done.
- Full/back-pressure: stall=1, push 5 words with DEPTH=4 -> 4 accepted, instr_ready=0, fifo_count=4, 5th held by source; release stall -> all 4 issue in order.
- Stall mid-instruction: repeat=3 load_bias; assert stall for 2 cycles after 1st strobe cycle -> load_bias shows 1,0,0,1,1,1 (4 total asserted cycles).
- Abort: queue 3 instructions, abort during the first -> outputs 0 next cycle, fifo_count=0, no seq_done, nothing further issued.
